// File: rtl/obi_sram_banked.sv
// obi_sram_banked: OBI subordinate over word-interleaved SRAM banks, with a credit-limited
// tag pipeline that tracks SRAM read latency and a bypassing in-order response buffer.
module obi_sram_banked #(
   parameter int unsigned NumWords    = 1024,
   parameter int unsigned DataWidth   = 32,
   parameter logic [31:0] BaseAddr    = 32'h0,
   parameter int unsigned NumBanks    = 2,
   parameter int unsigned SramLatency = 1,
   parameter int unsigned RspDepth    = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_i,
   output logic                   gnt_o,
   input  logic [31:0]            addr_i,
   input  logic                   we_i,
   input  logic [DataWidth/8-1:0] be_i,
   input  logic [DataWidth-1:0]   wdata_i,
   output logic                   rvalid_o,
   input  logic                   rready_i,
   output logic [DataWidth-1:0]   rdata_o,
   output logic                   err_o
);

   localparam int unsigned NumBytes   = DataWidth / 8;
   localparam int unsigned Rows       = NumWords / NumBanks;
   localparam int unsigned BankBits   = $clog2(NumBanks);
   localparam int unsigned BankW      = (NumBanks > 1) ? BankBits : 1;
   localparam int unsigned RowW       = (Rows > 1) ? $clog2(Rows) : 1;
   localparam int unsigned CntW       = $clog2(RspDepth + 1);
   localparam int unsigned PtrW       = (RspDepth > 1) ? $clog2(RspDepth) : 1;
   localparam int unsigned Last       = SramLatency - 1;
   localparam logic [32:0] RangeBytes = 33'(NumWords) << 2;

   // Address decode
   logic [31:0]          off;
   logic                 in_range;
   logic [BankW-1:0]     bank_sel;
   logic [RowW-1:0]      row_sel;
   logic [NumBanks-1:0]  bank_req;
   logic                 grant;
   logic                 accept;
   logic                 unused_off;

   assign off        = addr_i - BaseAddr;
   assign in_range   = ({1'b0, off} < RangeBytes);
   assign bank_sel   = (NumBanks > 1) ? off[2 +: BankW] : '0;
   assign row_sel    = off[2 + BankBits +: RowW];
   assign unused_off = ^off;

   always_comb begin
      bank_req = '0;
      if (grant && in_range) begin
         bank_req[bank_sel] = 1'b1;
      end
   end

   // Credits: grants outstanding until the response is accepted
   logic [CntW-1:0] cnt_q, cnt_d;

   assign gnt_o = !rst_i && (cnt_q < CntW'(RspDepth));
   assign grant = req_i && gnt_o;

   always_comb begin
      cnt_d = cnt_q;
      if (grant && !accept) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!grant && accept) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   // SRAM banks with a read-data shift chain matching SramLatency
   logic [DataWidth-1:0] bank_rdata [NumBanks];

   for (genvar b = 0; b < NumBanks; b++) begin : g_bank
      logic [DataWidth-1:0] mem_q [Rows];
      logic [DataWidth-1:0] rd_q  [SramLatency];
      logic [DataWidth-1:0] rd_d  [SramLatency];
      logic [DataWidth-1:0] wword_d;

      always_comb begin
         wword_d = mem_q[row_sel];
         for (int i = 0; i < NumBytes; i++) begin
            if (be_i[i]) begin
               wword_d[i*8 +: 8] = wdata_i[i*8 +: 8];
            end
         end
         rd_d[0] = (bank_req[b] && !we_i) ? mem_q[row_sel] : rd_q[0];
         for (int s = 1; s < SramLatency; s++) begin
            rd_d[s] = rd_q[s-1];
         end
      end

      always_ff @(posedge clk_i) begin
         if (bank_req[b] && we_i) begin
            mem_q[row_sel] <= wword_d;
         end
         for (int s = 0; s < SramLatency; s++) begin
            rd_q[s] <= rd_d[s];
         end
      end

      assign bank_rdata[b] = rd_q[Last];
   end

   // Tag pipeline, one stage per cycle of SRAM latency
   logic [SramLatency-1:0] vld_q, vld_d;
   logic [SramLatency-1:0] we_q, we_d;
   logic [SramLatency-1:0] err_q, err_d;
   logic [BankW-1:0]       bank_q [SramLatency];
   logic [BankW-1:0]       bank_d [SramLatency];

   always_comb begin
      vld_d[0]  = grant;
      we_d[0]   = we_i;
      err_d[0]  = !in_range;
      bank_d[0] = bank_sel;
      for (int s = 1; s < SramLatency; s++) begin
         vld_d[s]  = vld_q[s-1];
         we_d[s]   = we_q[s-1];
         err_d[s]  = err_q[s-1];
         bank_d[s] = bank_q[s-1];
      end
   end

   // Pipeline exit and response buffer with bypass when empty
   logic                 push;
   logic                 push_err;
   logic [DataWidth-1:0] push_data;
   logic                 fifo_empty;
   logic                 store;
   logic                 pop;
   logic                 head_err;
   logic [DataWidth-1:0] head_data;
   logic [DataWidth-1:0] fdata_q [RspDepth];
   logic [DataWidth-1:0] fdata_d [RspDepth];
   logic [RspDepth-1:0]  ferr_q, ferr_d;
   logic [PtrW-1:0]      rptr_q, rptr_d, wptr_q, wptr_d;
   logic [CntW-1:0]      fcnt_q, fcnt_d;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign push       = vld_q[Last];
   assign push_err   = err_q[Last];
   assign push_data  = (we_q[Last] || err_q[Last]) ? '0 : bank_rdata[bank_q[Last]];
   assign fifo_empty = (fcnt_q == '0);
   assign head_data  = fifo_empty ? push_data : fdata_q[rptr_q];
   assign head_err   = fifo_empty ? push_err : ferr_q[rptr_q];
   assign rvalid_o   = !rst_i && (!fifo_empty || push);
   assign rdata_o    = rvalid_o ? head_data : '0;
   assign err_o      = rvalid_o && head_err;
   assign accept     = rvalid_o && rready_i;
   assign pop        = accept && !fifo_empty;
   assign store      = push && !(fifo_empty && rready_i);

   always_comb begin
      fdata_d = fdata_q;
      ferr_d  = ferr_q;
      fcnt_d  = fcnt_q;
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      if (store) begin
         fdata_d[wptr_q] = push_data;
         ferr_d[wptr_q]  = push_err;
         wptr_d          = ptr_inc(wptr_q);
      end
      if (pop) begin
         rptr_d = ptr_inc(rptr_q);
      end
      if (store && !pop) begin
         fcnt_d = fcnt_q + CntW'(1);
      end else if (pop && !store) begin
         fcnt_d = fcnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         vld_q  <= '0;
         fcnt_q <= '0;
         rptr_q <= '0;
         wptr_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
         fcnt_q <= fcnt_d;
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
      end
      we_q    <= we_d;
      err_q   <= err_d;
      bank_q  <= bank_d;
      fdata_q <= fdata_d;
      ferr_q  <= ferr_d;
   end

   // Credits bound the in-flight count, so a push into a full buffer means broken accounting
   assert property (@(posedge clk_i) disable iff (rst_i)
      !(store && !pop && (fcnt_q == CntW'(RspDepth))))
      else $error("obi_sram_banked: response buffer overflow");

endmodule

// File: tb/tb_obi_sram_banked.sv
// Bench for obi_sram_banked: directed scenarios plus random traffic, checked against a
// transaction-level model (word-array memory, credit count, queue of timed responses).
module tb_obi_sram_banked;

   localparam int NW = 64;
   localparam int NB = 2;
   localparam int L  = 2;
   localparam int D  = 3;
   localparam logic [31:0] BASE = 32'h0000_4000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic        rready = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;
   logic        gnt, rvalid, err;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   obi_sram_banked #(
      .NumWords(NW), .DataWidth(32), .BaseAddr(BASE),
      .NumBanks(NB), .SramLatency(L), .RspDepth(D)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
      .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rready_i(rready),
      .rdata_o(rdata), .err_o(err)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          due;
   } rsp_t;

   logic [31:0] mem_m [NW];
   rsp_t        q [$];
   int          cnt_m = 0;
   int          cyc = 0;
   int          ncmp = 0;
   int          nfail = 0;

   // DUT-observed events of the last cycle
   logic          dg_flag, da_flag, da_err;
   logic [31:0]   da_data;
   logic [NB-1:0] dg_bank;
   int            dg_cyc, da_cyc, n_acc, first_acc, last_acc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic monitor();
      logic [31:0]   off;
      logic          inr;
      int            word;
      logic [NB-1:0] eb;
      bit            exp_g, exp_rv, g, a;
      rsp_t          r;
      dg_flag = req && gnt;
      da_flag = rvalid && rready;
      if (da_flag) begin
         da_data = rdata; da_err = err; da_cyc = cyc; n_acc++;
         if (first_acc < 0) first_acc = cyc;
         last_acc = cyc;
      end
      if (rst) begin
         chk("rst_gnt", gnt, 0);
         chk("rst_rvalid", rvalid, 0);
         chk("rst_rdata", rdata, 0);
         chk("rst_err", err, 0);
         q.delete();
         cnt_m = 0;
         return;
      end
      exp_g  = (cnt_m < D);
      exp_rv = (q.size() > 0) && (q[0].due <= cyc);
      chk("gnt", gnt, exp_g);
      chk("rvalid", rvalid, exp_rv);
      if (exp_rv) begin
         chk("rdata", rdata, q[0].data);
         chk("err", err, q[0].err);
      end
      off  = addr - BASE;
      inr  = (off < 32'(NW * 4));
      word = inr ? int'(off >> 2) : 0;
      g    = req && exp_g;
      a    = exp_rv && rready;
      eb   = '0;
      if (g && inr) eb[word % NB] = 1'b1;
      chk("bank_req", dut.bank_req, eb);
      if (dg_flag) begin
         dg_cyc = cyc; dg_bank = dut.bank_req;
      end
      if (a) void'(q.pop_front());
      if (g) begin
         if (we && inr) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem_m[word][8*b +: 8] = wdata[8*b +: 8];
            end
         end
         r.data = (we || !inr) ? 32'h0 : mem_m[word];
         r.err  = !inr;
         r.due  = cyc + L;
         q.push_back(r);
      end
      cnt_m = cnt_m + int'(g) - int'(a);
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic xfer(input logic w, input logic [31:0] ad, input logic [3:0] b,
                       input logic [31:0] wd);
      req = 1'b1; we = w; addr = ad; be = b; wdata = wd;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (dg_flag) break;
      end
      chk("grant_seen", dg_flag, 1);
      req = 1'b0;
   endtask

   task automatic wait_rsp(output logic [31:0] d, output logic e, output int c);
      req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (da_flag) break;
      end
      chk("rsp_seen", da_flag, 1);
      d = da_data; e = da_err; c = da_cyc;
   endtask

   task automatic drain();
      req = 1'b0; rready = 1'b1;
      for (int i = 0; i < 40 && q.size() > 0; i++) tick();
      tick();
      chk("drain_idle", rvalid, 0);
   endtask

   task automatic rand_phase(input int n);
      int k;
      for (int i = 0; i < n; i++) begin
         if (!req || dg_flag) begin
            req = ($urandom_range(0, 3) != 0);
            we  = 1'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 19));
            if (k == 0)      addr = BASE + 32'(NW * 4) + 32'(4 * $urandom_range(0, 15));
            else if (k == 1) addr = BASE - 32'(4 * $urandom_range(1, 16));
            else             addr = BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(0, 3));
            be    = 4'($urandom);
            wdata = $urandom;
         end
         rready = ($urandom_range(0, 3) != 0);
         tick();
      end
   endtask

   logic [31:0] d;
   logic        e;
   int          c, gc, n;

   initial begin
      n_acc = 0; first_acc = -1; last_acc = -1;
      // reset state
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b0;

      for (int w = 0; w < NW; w++) xfer(1'b1, BASE + 32'(4 * w), 4'hF, $urandom);
      drain();

      // full write then read, latency and bank selection
      xfer(1'b1, BASE + 32'h4, 4'hF, 32'hDEAD_BEEF);
      chk("t2_wr_bank", dg_bank, 2'b10);
      drain();
      xfer(1'b0, BASE + 32'h4, 4'h0, 32'h0);
      gc = dg_cyc;
      chk("t2_rd_bank", dg_bank, 2'b10);
      wait_rsp(d, e, c);
      chk("t2_lat", c - gc, L);
      chk("t2_data", d, 32'hDEAD_BEEF);
      chk("t2_err", e, 0);

      // partial write merges a single byte lane
      xfer(1'b1, BASE + 32'h8, 4'hF, 32'h1122_3344);
      xfer(1'b1, BASE + 32'h8, 4'b0010, 32'h0000_AB00);
      drain();
      xfer(1'b0, BASE + 32'h8, 4'h0, 32'h0);
      wait_rsp(d, e, c);
      chk("t3_data", d, 32'h1122_AB44);

      // write immediately followed by read of the same word
      xfer(1'b1, BASE + 32'h10, 4'hF, 32'hCAFE_F00D);
      xfer(1'b0, BASE + 32'h10, 4'h0, 32'h0);
      drain();

      // out of range above the window and below it (wrap)
      xfer(1'b0, BASE + 32'(NW * 4), 4'h0, 32'h0);
      chk("t4_hi_bank", dg_bank, 0);
      wait_rsp(d, e, c);
      chk("t4_hi_err", e, 1);
      chk("t4_hi_data", d, 0);
      xfer(1'b0, BASE - 32'h4, 4'h0, 32'h0);
      chk("t4_lo_bank", dg_bank, 0);
      wait_rsp(d, e, c);
      chk("t4_lo_err", e, 1);
      drain();

      // back-pressure: only RspDepth reads get in while rready is low
      rready = 1'b0; n = 0;
      for (int i = 0; i < D + 3; i++) begin
         req = 1'b1; we = 1'b0; addr = BASE + 32'(4 * (20 + n));
         tick();
         if (dg_flag) n++;
      end
      chk("t5_grants", n, D);
      chk("t5_gnt_low", gnt, 0);
      req = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rready = 1'b1;
      for (int k = 0; k < D; k++) begin
         wait_rsp(d, e, c);
         chk("t5_data", d, mem_m[20 + k]);
      end
      drain();

      // throughput: back-to-back reads across alternating banks
      rready = 1'b1; n = 0; n_acc = 0; first_acc = -1;
      for (int i = 0; i < 64; i++) begin
         req = 1'b1; we = 1'b0; addr = BASE + 32'(4 * (i % NW));
         tick();
         if (dg_flag) n++;
      end
      req = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("t6_grants", n, 64);
      chk("t6_rsps", n_acc, 64);
      chk("t6_span", last_acc - first_acc + 1, 64);

      rand_phase(250);

      // reset mid-burst with req held high
      req = 1'b1; we = 1'b0; addr = BASE + 32'h8; rready = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b0; rready = 1'b1;
      tick();
      chk("t1_first_grant", dg_flag, 1);

      rand_phase(150);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
